// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: carrier LUTs, symbol map and demodulator state type.
package qpsk_pkg;

    localparam int unsigned LUT_SIZE = 16;
    localparam int unsigned LUT_W    = 8;
    localparam int unsigned PHASE_W  = $clog2(LUT_SIZE);

    localparam logic signed [LUT_W-1:0] COS_LUT [LUT_SIZE] = '{
        8'sd127,  8'sd118,  8'sd90,   8'sd49,
        8'sd0,   -8'sd49,  -8'sd90,  -8'sd118,
       -8'sd127, -8'sd118, -8'sd90,  -8'sd49,
        8'sd0,    8'sd49,   8'sd90,   8'sd118
    };

    // sin[k] = cos[(k+12) mod 16]
    localparam logic signed [LUT_W-1:0] SIN_LUT [LUT_SIZE] = '{
        8'sd0,    8'sd49,   8'sd90,   8'sd118,
        8'sd127,  8'sd118,  8'sd90,   8'sd49,
        8'sd0,   -8'sd49,  -8'sd90,  -8'sd118,
       -8'sd127, -8'sd118, -8'sd90,  -8'sd49
    };

    // Pair {b1,b0} -> (I sign, Q sign): b0 selects I polarity, b1 selects Q polarity.
    localparam logic [1:0] SYM_PP = 2'b00;
    localparam logic [1:0] SYM_MP = 2'b01;
    localparam logic [1:0] SYM_MM = 2'b11;
    localparam logic [1:0] SYM_PM = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTEG = 2'd1,
        DUMP  = 2'd2
    } demod_state_e;

    function automatic logic [1:0] sym_decide(input logic i_neg, input logic q_neg);
        return {q_neg, i_neg};
    endfunction

endpackage

// File: rtl/qpsk_bit_serializer.sv
// Single-pair output buffer that shifts the decided pair out older-bit-first
// on a ready/valid stream and flags pairs lost to a full buffer.
module qpsk_bit_serializer
    import qpsk_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [1:0] pair_in,
    input  logic       bit_ready,
    output logic       bit_out,
    output logic       bit_valid,
    output logic       overrun
);

    logic [1:0] pair_q, pair_d;
    logic [1:0] cnt_q, cnt_d;
    logic       bit_out_q, bit_out_d;
    logic       bit_valid_q, bit_valid_d;
    logic       overrun_q, overrun_d;
    logic       pop_c;
    logic [1:0] cnt_after_pop_c;

    always_comb begin
        pair_d          = pair_q;
        overrun_d       = overrun_q;
        pop_c           = bit_valid_q & bit_ready;
        cnt_after_pop_c = pop_c ? (cnt_q - 2'd1) : cnt_q;
        cnt_d           = cnt_after_pop_c;

        // A new pair is only accepted once both bits of the old one have left.
        if (push) begin
            if (cnt_after_pop_c == 2'd0) begin
                pair_d = pair_in;
                cnt_d  = 2'd2;
            end else begin
                overrun_d = 1'b1;
            end
        end

        bit_valid_d = (cnt_d != 2'd0);
        case (cnt_d)
            2'd2:    bit_out_d = pair_d[1];
            2'd1:    bit_out_d = pair_d[0];
            default: bit_out_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q      <= '0;
            cnt_q       <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            pair_q      <= pair_d;
            cnt_q       <= cnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: rtl/qpsk_demodulator.sv
// Coherent QPSK receiver: LUT mixer, per-symbol integrate-and-dump on I/Q,
// sign decision and serial bit output.
module qpsk_demodulator
    import qpsk_pkg::*;
#(
    parameter int unsigned SYMBOL_LEN = 16,
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned ACC_W      = SAMPLE_W + 8 + $clog2(SYMBOL_LEN) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       sym_start,
    output logic                       bit_out,
    output logic                       bit_valid,
    input  logic                       bit_ready,
    output logic [1:0]                 sym_pair,
    output logic                       sym_done,
    output logic signed [ACC_W-1:0]    i_acc,
    output logic signed [ACC_W-1:0]    q_acc,
    output logic                       overrun
);

    localparam int unsigned CNT_W  = $clog2(SYMBOL_LEN);
    localparam int unsigned PROD_W = SAMPLE_W + LUT_W;

    demod_state_e                state_q, state_d;
    logic [PHASE_W-1:0]          phase_q, phase_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [ACC_W-1:0]     acc_i_q, acc_i_d;
    logic signed [ACC_W-1:0]     acc_q_q, acc_q_d;
    logic signed [ACC_W-1:0]     i_acc_q, i_acc_d;
    logic signed [ACC_W-1:0]     q_acc_q, q_acc_d;
    logic [1:0]                  sym_pair_q, sym_pair_d;
    logic                        sym_done_q, sym_done_d;

    logic [PHASE_W-1:0]          mix_phase_c;
    logic signed [LUT_W-1:0]     cos_c;
    logic signed [LUT_W-1:0]     nsin_c;
    logic signed [PROD_W-1:0]    prod_i_c;
    logic signed [PROD_W-1:0]    prod_q_c;
    logic signed [ACC_W-1:0]     ext_i_c;
    logic signed [ACC_W-1:0]     ext_q_c;
    logic                        push_c;
    logic [1:0]                  push_pair_c;

    // Mixer: a sym_start sample is always taken at carrier phase 0.
    always_comb begin
        mix_phase_c = sym_start ? '0 : phase_q;
        cos_c       = COS_LUT[mix_phase_c];
        nsin_c      = -SIN_LUT[mix_phase_c];
        prod_i_c    = PROD_W'(sample_in) * PROD_W'(cos_c);
        prod_q_c    = PROD_W'(sample_in) * PROD_W'(nsin_c);
        ext_i_c     = ACC_W'(prod_i_c);
        ext_q_c     = ACC_W'(prod_q_c);
    end

    // Integrate-and-dump control.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        i_acc_d     = i_acc_q;
        q_acc_d     = q_acc_q;
        sym_pair_d  = sym_pair_q;
        sym_done_d  = 1'b0;
        push_c      = 1'b0;
        push_pair_c = sym_decide(acc_i_q[ACC_W-1], acc_q_q[ACC_W-1]);

        if (!enable) begin
            state_d = IDLE;
            phase_d = '0;
            cnt_d   = '0;
            acc_i_d = '0;
            acc_q_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    acc_i_d = '0;
                    acc_q_d = '0;
                    phase_d = '0;
                    cnt_d   = '0;
                    if (sample_valid && sym_start) begin
                        state_d = INTEG;
                        acc_i_d = ext_i_c;
                        acc_q_d = ext_q_c;
                        phase_d = PHASE_W'(1);
                        cnt_d   = CNT_W'(1);
                    end
                end

                INTEG: begin
                    if (sample_valid) begin
                        if (sym_start) begin
                            acc_i_d = ext_i_c;
                            acc_q_d = ext_q_c;
                            phase_d = PHASE_W'(1);
                            cnt_d   = CNT_W'(1);
                        end else begin
                            acc_i_d = acc_i_q + ext_i_c;
                            acc_q_d = acc_q_q + ext_q_c;
                            phase_d = phase_q + PHASE_W'(1);
                            cnt_d   = cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_W'(SYMBOL_LEN - 1)) begin
                                state_d = DUMP;
                            end
                        end
                    end
                end

                DUMP: begin
                    i_acc_d    = acc_i_q;
                    q_acc_d    = acc_q_q;
                    sym_pair_d = push_pair_c;
                    sym_done_d = 1'b1;
                    push_c     = 1'b1;
                    acc_i_d    = '0;
                    acc_q_d    = '0;
                    phase_d    = '0;
                    cnt_d      = '0;
                    state_d    = INTEG;
                end

                default: begin
                    state_d = IDLE;
                    acc_i_d = '0;
                    acc_q_d = '0;
                    phase_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            cnt_q      <= '0;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            i_acc_q    <= '0;
            q_acc_q    <= '0;
            sym_pair_q <= '0;
            sym_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            acc_i_q    <= acc_i_d;
            acc_q_q    <= acc_q_d;
            i_acc_q    <= i_acc_d;
            q_acc_q    <= q_acc_d;
            sym_pair_q <= sym_pair_d;
            sym_done_q <= sym_done_d;
        end
    end

    qpsk_bit_serializer u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .pair_in   (push_pair_c),
        .bit_ready (bit_ready),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .overrun   (overrun)
    );

    assign sym_pair = sym_pair_q;
    assign sym_done = sym_done_q;
    assign i_acc    = i_acc_q;
    assign q_acc    = q_acc_q;

endmodule

// File: tb/tb_qpsk_demodulator.sv
// Self-checking bench for qpsk_demodulator: modulator model feeds symbols,
// a scoreboard checks per-symbol correlations and the serial bit stream.
module tb_qpsk_demodulator;

    localparam int unsigned SYMBOL_LEN = 16;
    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned ACC_W      = SAMPLE_W + 8 + $clog2(SYMBOL_LEN) + 1;

    localparam int COS_T [16] = '{127, 118, 90, 49, 0, -49, -90, -118,
                                  -127, -118, -90, -49, 0, 49, 90, 118};

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       enable;
    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       sample_valid;
    logic                       sym_start;
    logic                       bit_out;
    logic                       bit_valid;
    logic                       bit_ready;
    logic [1:0]                 sym_pair;
    logic                       sym_done;
    logic signed [ACC_W-1:0]    i_acc;
    logic signed [ACC_W-1:0]    q_acc;
    logic                       overrun;

    always #5 clk = ~clk;

    qpsk_demodulator #(
        .SYMBOL_LEN (SYMBOL_LEN),
        .SAMPLE_W   (SAMPLE_W),
        .ACC_W      (ACC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sym_start    (sym_start),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .sym_pair     (sym_pair),
        .sym_done     (sym_done),
        .i_acc        (i_acc),
        .q_acc        (q_acc),
        .overrun      (overrun)
    );

    typedef struct {
        longint     i;
        longint     q;
        logic [1:0] pair;
    } sym_exp_t;

    typedef struct {
        int         ia;
        int         qa;
        logic [1:0] pair;
    } vec_t;

    sym_exp_t sym_q [$];
    logic     bit_q [$];
    int       n_total = 0;
    int       n_pass  = 0;
    vec_t     vecs [4];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int mod_sample(input int ia, input int qa, input int k);
        int c;
        int s;
        c = COS_T[k];
        s = COS_T[(k + 12) % 16];
        return (ia * c - qa * s) >>> 7;
    endfunction

    task automatic drive(input bit v, input bit st, input int smp);
        @(posedge clk);
        #1;
        sample_valid = v;
        sym_start    = st;
        sample_in    = SAMPLE_W'(smp);
    endtask

    task automatic send_symbol(input int ia, input int qa, input logic [1:0] exp_pair,
                               input bit gap, input bit want_bits);
        sym_exp_t e;
        int s;
        e.i = 0;
        e.q = 0;
        e.pair = exp_pair;
        for (int k = 0; k < 16; k++) begin
            s = mod_sample(ia, qa, k);
            e.i += longint'(s * COS_T[k]);
            e.q += longint'(s * (-COS_T[(k + 12) % 16]));
        end
        sym_q.push_back(e);
        if (want_bits) begin
            bit_q.push_back(exp_pair[1]);
            bit_q.push_back(exp_pair[0]);
        end
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, k == 0, mod_sample(ia, qa, k));
            if (gap) drive(1'b0, 1'b0, int'($urandom_range(0, 65535)));
        end
        drive(1'b0, 1'b0, 0);
    endtask

    task automatic send_partial(input int ia, input int qa, input int n);
        for (int k = 0; k < n; k++) drive(1'b1, k == 0, mod_sample(ia, qa, k));
    endtask

    // Scoreboard consumer: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin : monitor
        sym_exp_t e;
        if (sym_done) begin
            if (sym_q.size() == 0) begin
                chk("unexpected_sym_done", 1, 0);
            end else begin
                e = sym_q.pop_front();
                chk("i_acc", longint'(i_acc), e.i);
                chk("q_acc", longint'(q_acc), e.q);
                chk("sym_pair", longint'(sym_pair), longint'(e.pair));
            end
        end
        if (bit_valid && bit_ready) begin
            if (bit_q.size() == 0) chk("unexpected_bit", 1, 0);
            else chk("bit_out", longint'(bit_out), longint'(bit_q.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{ia:  127, qa:  127, pair: 2'b00};
        vecs[1] = '{ia: -127, qa:  127, pair: 2'b01};
        vecs[2] = '{ia: -127, qa: -127, pair: 2'b11};
        vecs[3] = '{ia:  127, qa: -127, pair: 2'b10};

        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        sym_start    = 1'b0;
        bit_ready    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bit_valid", longint'(bit_valid), 0);
        chk("rst_bit_out",   longint'(bit_out),   0);
        chk("rst_sym_done",  longint'(sym_done),  0);
        chk("rst_sym_pair",  longint'(sym_pair),  0);
        chk("rst_i_acc",     longint'(i_acc),     0);
        chk("rst_q_acc",     longint'(q_acc),     0);
        chk("rst_overrun",   longint'(overrun),   0);
        rst_n     = 1'b1;
        enable    = 1'b1;
        bit_ready = 1'b1;

        // Single pair 00 with latency and pulse-width checks.
        send_symbol(vecs[0].ia, vecs[0].qa, vecs[0].pair, 1'b0, 1'b1);
        @(negedge clk);
        chk("valid_in_dump", longint'(bit_valid), 0);
        chk("done_in_dump",  longint'(sym_done),  0);
        @(negedge clk);
        chk("first_bit_latency", longint'(bit_valid), 1);
        chk("sym_done_pulse",    longint'(sym_done),  1);
        chk("i_acc_large", longint'(i_acc > 120000), 1);
        chk("q_acc_large", longint'(q_acc > 120000), 1);
        @(negedge clk);
        chk("sym_done_one_cycle", longint'(sym_done),  0);
        chk("second_bit_valid",   longint'(bit_valid), 1);
        @(negedge clk);
        chk("drained_after_pair", longint'(bit_valid), 0);

        // Four pairs back to back, continuous samples.
        for (int v = 0; v < 4; v++) send_symbol(vecs[v].ia, vecs[v].qa, vecs[v].pair, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("no_overrun_streaming", longint'(overrun), 0);

        // Same pairs with sample_valid toggling every other cycle.
        for (int v = 0; v < 4; v++) send_symbol(vecs[v].ia, vecs[v].qa, vecs[v].pair, 1'b1, 1'b1);
        repeat (4) @(negedge clk);

        // Resync: sym_start at sample 7 restarts the window.
        send_partial(vecs[2].ia, vecs[2].qa, 7);
        send_symbol(vecs[3].ia, vecs[3].qa, vecs[3].pair, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        chk("no_overrun_resync", longint'(overrun), 0);

        // Back-pressure across two symbols: second pair is dropped.
        bit_ready = 1'b0;
        send_symbol(vecs[3].ia, vecs[3].qa, vecs[3].pair, 1'b0, 1'b1);
        send_symbol(vecs[1].ia, vecs[1].qa, vecs[1].pair, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("overrun_set",      longint'(overrun),   1);
        chk("held_bit_valid",   longint'(bit_valid), 1);
        chk("held_bit_out",     longint'(bit_out),   1);
        repeat (4) @(posedge clk);
        #1 bit_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("overrun_bits_left", longint'(bit_q.size()), 0);
        chk("overrun_drained",   longint'(bit_valid),    0);
        chk("overrun_sticky",    longint'(overrun),      1);

        // Asynchronous reset mid-symbol with bits pending.
        bit_ready = 1'b0;
        send_symbol(vecs[2].ia, vecs[2].qa, vecs[2].pair, 1'b0, 1'b1);
        send_partial(vecs[0].ia, vecs[0].qa, 5);
        #2 rst_n = 1'b0;
        #1;
        bit_q.delete();
        sample_valid = 1'b0;
        sym_start    = 1'b0;
        chk("arst_bit_valid", longint'(bit_valid), 0);
        chk("arst_bit_out",   longint'(bit_out),   0);
        chk("arst_sym_pair",  longint'(sym_pair),  0);
        chk("arst_i_acc",     longint'(i_acc),     0);
        chk("arst_q_acc",     longint'(q_acc),     0);
        chk("arst_overrun",   longint'(overrun),   0);
        @(negedge clk);
        rst_n     = 1'b1;
        bit_ready = 1'b1;
        for (int k = 5; k < 16; k++) drive(1'b1, 1'b0, mod_sample(vecs[0].ia, vecs[0].qa, k));
        drive(1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("no_valid_before_start", longint'(bit_valid), 0);
        send_symbol(vecs[1].ia, vecs[1].qa, vecs[1].pair, 1'b0, 1'b1);

        for (int t = 0; t < 50 && (sym_q.size() != 0 || bit_q.size() != 0); t++) @(negedge clk);
        chk("scoreboard_empty", longint'(sym_q.size() + bit_q.size()), 0);
        chk("final_overrun", longint'(overrun), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
